// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, GF(2^8) arithmetic, S-boxes and Rcon.
// The S-boxes are computed as GF inverse plus affine map rather than stored tables.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        EXPAND,
        ADDKEY,
        ROUND,
        FINAL
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // a^254 is the multiplicative inverse, with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
                 ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] x;
        x = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(x);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: combinational InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// last bypasses InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] ark;
    logic [127:0] mix;
    logic [7:0]   b0, b1, b2, b3;

    // Row r of the input moves right by r columns before substitution
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8])
                    ^ round_key[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    always_comb begin
        mix = '0;
        b0  = '0;
        b1  = '0;
        b2  = '0;
        b3  = '0;
        for (int c = 0; c < 4; c++) begin
            b0 = ark[127 - 32*c -: 8];
            b1 = ark[119 - 32*c -: 8];
            b2 = ark[111 - 32*c -: 8];
            b3 = ark[103 - 32*c -: 8];
            mix[127 - 32*c -: 32] = {
                mul14(b0) ^ mul11(b1) ^ mul13(b2) ^ mul9(b3),
                mul9(b0)  ^ mul14(b1) ^ mul11(b2) ^ mul13(b3),
                mul13(b0) ^ mul9(b1)  ^ mul14(b2) ^ mul11(b3),
                mul11(b0) ^ mul13(b1) ^ mul9(b2)  ^ mul14(b3)
            };
        end
    end

    assign state_out = last ? ark : mix;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 decryption, one inverse round per clock.
// Define AES_DEC_KEY_CACHE_EN to cache k10 for a repeated cipher key.
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] Data_In,
    input  logic [127:0] Key_In,
    output logic         Busy,
    output logic         Done,
    output logic [127:0] Data_Out
);

    state_e      fsm_q, fsm_d;
    logic [3:0]  round_q, round_d;
    block_t      blk_q, blk_d;
    block_t      key_q, key_d;
    block_t      dout_q, dout_d;
    logic        done_q, done_d;
    logic        hit;
    block_t      cached_k10;
    block_t      rnd_out;
    block_t      key_fwd, key_inv;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] i0, i1, i2, i3;
    logic [7:0]  rc;

    assign {w0, w1, w2, w3} = key_q;
    assign rc = rcon(round_q);

    assign f0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign key_fwd = {f0, f1, f2, f3};

    // Unwinding uses Rcon of the round whose key is currently held
    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ sub_word({i3[23:0], i3[31:24]}) ^ {rc, 24'h0};
    assign key_inv = {i0, i1, i2, i3};

    aes_inv_round u_round (
        .state_in  (blk_q),
        .round_key (key_q),
        .last      (fsm_q == FINAL),
        .state_out (rnd_out)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    logic   cache_vld_q;
    block_t cache_key_q;
    block_t cache_k10_q;

    assign hit        = cache_vld_q && (Key_In == cache_key_q);
    assign cached_k10 = cache_k10_q;

    // Key is recorded on a missed acceptance; valid only once EXPAND completes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_k10_q <= '0;
        end else begin
            if (fsm_q == IDLE && Start && !hit) begin
                cache_key_q <= Key_In;
                cache_vld_q <= 1'b0;
            end
            if (fsm_q == EXPAND && round_q == 4'd10) begin
                cache_k10_q <= key_fwd;
                cache_vld_q <= 1'b1;
            end
        end
    end
`else
    assign hit        = 1'b0;
    assign cached_k10 = '0;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        key_d   = key_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (Start) begin
                    blk_d = Data_In;
                    if (hit) begin
                        key_d   = cached_k10;
                        round_d = 4'd10;
                        fsm_d   = ADDKEY;
                    end else begin
                        key_d   = Key_In;
                        round_d = 4'd1;
                        fsm_d   = EXPAND;
                    end
                end
            end
            EXPAND: begin
                key_d = key_fwd;
                if (round_q == 4'd10) fsm_d = ADDKEY;
                else round_d = round_q + 4'd1;
            end
            ADDKEY: begin
                blk_d   = blk_q ^ key_q;
                key_d   = key_inv;
                round_d = 4'd9;
                fsm_d   = ROUND;
            end
            ROUND: begin
                blk_d   = rnd_out;
                key_d   = key_inv;
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                dout_d  = rnd_out;
                done_d  = 1'b1;
                round_d = 4'd0;
                fsm_d   = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign Busy     = (fsm_q != IDLE);
    assign Done     = done_q;
    assign Data_Out = dout_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed FIPS-197 vectors plus random blocks
// checked against an array-based AES-128 reference decryption.
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] din;
    logic [127:0] kin;
    logic         busy;
    logic         done;
    logic [127:0] dout;

    int errors = 0;
    int checks = 0;

    bit           cvld;
    logic [127:0] ckey;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 clk = ~clk;

    aes_inv_cipher_iter dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .Data_In  (din),
        .Key_In   (kin),
        .Busy     (busy),
        .Done     (done),
        .Data_Out (dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int rl(int q, int n);
        return ((q << n) | (q >> (8 - n))) & 'hff;
    endfunction

    // S-box from walking the multiplicative group with generator 3
    task automatic build_sbox();
        int p;
        int q;
        int x;
        p = 1;
        q = 1;
        do begin
            p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 'hff;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            q = q & 'hff;
            if ((q & 'h80) != 0) q = q ^ 'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = 8'(x ^ 'h63);
        end while (p != 1);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ ('h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] key,
                                               input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]],
                       sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = ct[127 - 8*i -: 8] ^ w[40 + i/4][31 - 8*(i%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*((c + row) % 4) + row] = isb[s[4*c + row]];
            for (int i = 0; i < 16; i++)
                t[i] = t[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gm(t[4*c], 8'd14) ^ gm(t[4*c+1], 8'd11)
                             ^ gm(t[4*c+2], 8'd13) ^ gm(t[4*c+3], 8'd9);
                    s[4*c+1] = gm(t[4*c], 8'd9) ^ gm(t[4*c+1], 8'd14)
                             ^ gm(t[4*c+2], 8'd11) ^ gm(t[4*c+3], 8'd13);
                    s[4*c+2] = gm(t[4*c], 8'd13) ^ gm(t[4*c+1], 8'd9)
                             ^ gm(t[4*c+2], 8'd14) ^ gm(t[4*c+3], 8'd11);
                    s[4*c+3] = gm(t[4*c], 8'd11) ^ gm(t[4*c+1], 8'd13)
                             ^ gm(t[4*c+2], 8'd9) ^ gm(t[4*c+3], 8'd14);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic int exp_lat(input logic [127:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
        return (cvld && key == ckey) ? 11 : 21;
`else
        return 21;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cvld = 1'b0;
    endtask

    task automatic run(input string tag, input logic [127:0] key,
                       input logic [127:0] ct, input logic [127:0] pt,
                       input bit chk_k10);
        int lat;
        int el;
        el = exp_lat(key);
        start = 1'b1;
        din = ct;
        kin = key;
        step();
        start = 1'b0;
        din = rnd128();
        kin = rnd128();
        chk({tag, ".busy"}, 128'(busy), 128'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (chk_k10 && el == 21 && n == 10)
                chk({tag, ".k10"}, dut.key_q, B_K10);
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, ".latency"}, 128'(lat), 128'(el));
        chk({tag, ".data"}, dout, pt);
        cvld = 1'b1;
        ckey = key;
        step();
        chk({tag, ".done_drop"}, 128'(done), 128'd0);
        chk({tag, ".hold"}, dout, pt);
    endtask

    initial begin
        int ndone;
        int nbusy_low;
        int lat;
        int unstable;
        int el;
        logic [127:0] k;
        logic [127:0] ct;

        rst = 1'b1;
        start = 1'b0;
        din = '0;
        kin = '0;
        cvld = 1'b0;
        ckey = '0;
        build_sbox();
        step();
        step();
        rst = 1'b0;
        chk("reset.busy", 128'(busy), 128'd0);
        chk("reset.done", 128'(done), 128'd0);
        chk("reset.dout", dout, 128'd0);

        run("c1", C1_KEY, C1_CT, C1_PT, 1'b0);
        run("appb", B_KEY, B_CT, B_PT, 1'b1);

        // Start held high across a whole block and one re-acceptance
        el = exp_lat(C1_KEY);
        start = 1'b1;
        din = C1_CT;
        kin = C1_KEY;
        step();
        ndone = 0;
        nbusy_low = 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin
                ndone++;
                lat = n;
                break;
            end
            if (!busy) nbusy_low++;
        end
        chk("held.lat1", 128'(lat), 128'(el));
        chk("held.ndone1", 128'(ndone), 128'd1);
        chk("held.busy_gap", 128'(nbusy_low), 128'd0);
        chk("held.data1", dout, C1_PT);
        cvld = 1'b1;
        ckey = C1_KEY;
        el = exp_lat(C1_KEY);
        step();
        start = 1'b0;
        chk("held.reaccept", 128'(busy), 128'd1);
        chk("held.done_drop", 128'(done), 128'd0);
        lat = 0;
        unstable = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
            if (dout !== C1_PT) unstable++;
        end
        chk("held.lat2", 128'(lat), 128'(el));
        chk("held.stable", 128'(unstable), 128'd0);
        chk("held.data2", dout, C1_PT);
        step();

        // Abort in ROUND at E15 with a fresh key
        k = rnd128();
        ct = rnd128();
        start = 1'b1;
        din = ct;
        kin = k;
        step();
        start = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (done) ndone++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cvld = 1'b0;
        chk("abort.busy", 128'(busy), 128'd0);
        chk("abort.done", 128'(done), 128'd0);
        chk("abort.dout", dout, 128'd0);
        ndone = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (done) ndone++;
        end
        chk("abort.no_done", 128'(ndone), 128'd0);
        run("after_abort", C1_KEY, C1_CT, C1_PT, 1'b0);

        run("appb_a", B_KEY, B_CT, B_PT, 1'b1);
        run("appb_b", B_KEY, B_CT, B_PT, 1'b0);
        run("c1_again", C1_KEY, C1_CT, C1_PT, 1'b0);
        run("appb_pre", B_KEY, B_CT, B_PT, 1'b0);
        do_reset();
        run("appb_post_rst", B_KEY, B_CT, B_PT, 1'b1);

        k = rnd128();
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 0) k = rnd128();
            ct = rnd128();
            run($sformatf("rand%0d", i), k, ct, model_dec(k, ct), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 decryption core, one inverse round per clock. It is the receive-side counterpart of the encryption round datapath. It accepts a 128-bit ciphertext block and the 128-bit cipher key, runs the key schedule forward to round key 10, then unwinds the schedule on the fly while applying InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. It returns the plaintext with a one-cycle done pulse. It sits beside the encryption datapath at the block-cipher level and presents a simple start/busy/done handshake to the controlling logic.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- Clk  input  1  rising-edge clock, single clock domain
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only while Busy=0
- Data_In  input  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197
- Key_In  input  128  cipher key (round key 0), same byte order
- Busy  output  1  high from the cycle after Start acceptance until Done
- Done  output  1  single-cycle pulse; Data_Out valid from this cycle
- Data_Out  output  128  plaintext; holds until the next Done

## Operation
- FSM states:
  - IDLE: on Start=1, capture Data_In into the state register and Key_In into the key register, then go to EXPAND.
  - EXPAND: 10 cycles with Round_Count 1..10. Key reg <= forward schedule(key, Rcon[Round_Count]). Key reg ends holding k10.
  - ADDKEY: 1 cycle. State <= state ^ k10. Key reg <= k9. Round_Count=10.
  - ROUND: 9 cycles with Round_Count 9..1. State <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k_r). Key reg <= k_{r-1}.
  - FINAL: 1 cycle. Data_Out <= InvSubBytes(InvShiftRows(state)) ^ k0. Done <= 1. Go to IDLE.
- Inverse key step, from k_r to k_{r-1} with words w0..w3:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Round_Count is 4-bit internal. Values 0 and 11..15 are never used in arithmetic.
- Start while Busy=1 is ignored; there is no queueing.
- Start in the same cycle as Done (FSM already in IDLE next cycle) is accepted on the following edge normally.
- Data_In and Key_In are don't-care after the acceptance edge.
- Rst at any cycle, including mid-EXPAND or mid-ROUND, forces the following on the next edge:
  - FSM to IDLE.
  - Busy=0, Done=0, Data_Out=0, Round_Count=0, state and key registers = 0.
  - Key cache invalidated (if compiled in).
  - The in-flight block is discarded with no Done.

## Timing
- Reset values: Busy=0, Done=0, Data_Out=128'h0.
- Edge E0 samples Start=1; Busy=1 from E0.
- Latency without cache hit:
  - EXPAND on E1..E10, ADDKEY on E11, ROUND on E12..E20, FINAL on E21.
  - Done=1 and Data_Out valid after E21 (21 cycles). Busy=0 after E21.
- Latency with cache hit: ADDKEY on E1, ROUND on E2..E10, FINAL on E11, giving 11 cycles.
- Done deasserts on the edge after it rises. Data_Out is unchanged until the next FINAL or Rst.
- Throughput: one block per 22 cycles (12 with cache hit), counting the idle cycle.

## Configuration
- AES_DEC_KEY_CACHE_EN defined:
  - Adds a 128-bit cached cipher key, the 128-bit cached k10, and a valid bit.
  - On acceptance with a valid cache and Key_In equal to the cached key, skip EXPAND and load k10 from the cache.
  - On each completed EXPAND, write both cache entries and set valid.
  - Rst clears valid.
- AES_DEC_KEY_CACHE_EN undefined: no cache storage; every block runs EXPAND (fixed 21-cycle latency).

## Structure
- Shared package aes_pkg holds:
  - forward and inverse S-box functions
  - xtime/GF(2^8) multiply-by-9/11/13/14 functions
  - Rcon table
  - 128-bit block typedef
  - FSM state enum (IDLE, EXPAND, ADDKEY, ROUND, FINAL)
- One sub-module, aes_inv_round: combinational InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns, with a Last input that bypasses InvMixColumns. The forward and inverse key-step logic stays in the top module.

## Test plan
- FIPS-197 C.1: Key_In=000102030405060708090a0b0c0d0e0f, Data_In=69c4e0d86a7b0430d8cdb78070b4c55a, pulse Start. Expected: Done exactly 21 cycles later, Data_Out=00112233445566778899aabbccddeeff.
- FIPS-197 App. B: Key_In=2b7e151628aed2a6abf7158809cf4f3c, Data_In=3925841d02dc09fbdc118597196a0b32. Expected: internal key reg after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6; Data_Out=3243f6a8885a308d313198a2e0370734.
- Start held high throughout the C.1 run. Expected: no second acceptance until the cycle after Done, exactly one Done per accepted block, Data_Out stable between pulses.
- Rst asserted during ROUND (E15), then a new C.1 Start. Expected: no Done for the aborted block; Busy, Done and Data_Out read 0 after Rst; the new block completes correctly in 21 cycles.
- With AES_DEC_KEY_CACHE_EN, App. B twice back-to-back with the same key. Expected: first Done at 21 cycles, second at 11, same plaintext. Then C.1 key: 21 cycles.
- With AES_DEC_KEY_CACHE_EN, the App. B key, then Rst, then the same key again. Expected: 21 cycles, because the cache is invalidated by Rst.
